// File: rtl/muldiv_sched_pkg.sv
// Shared definitions for the EXE-stage multiply/divide sequencer:
// FSM state encodings and request-op bit positions.
package muldiv_sched_pkg;

  typedef enum logic [2:0] {
    MD_IDLE  = 3'd0,
    MD_MUL   = 3'd1,
    MD_DSEND = 3'd2,
    MD_DWAIT = 3'd3,
    MD_DONE  = 3'd4,
    MD_DRAIN = 3'd5
  } md_state_e;

  // Positions of the mult/div bits inside the wide alu_op bus; req_op is that 4-bit slice.
  localparam int ALU_OP_MULT  = 12;
  localparam int ALU_OP_MULTU = 13;
  localparam int ALU_OP_DIV   = 14;
  localparam int ALU_OP_DIVU  = 15;

  localparam int OP_W     = 4;
  localparam int OP_MULT  = ALU_OP_MULT  - ALU_OP_MULT;
  localparam int OP_MULTU = ALU_OP_MULTU - ALU_OP_MULT;
  localparam int OP_DIV   = ALU_OP_DIV   - ALU_OP_MULT;
  localparam int OP_DIVU  = ALU_OP_DIVU  - ALU_OP_MULT;

  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op[OP_DIV] | op[OP_DIVU];
  endfunction

  function automatic logic op_is_signed(input logic [OP_W-1:0] op);
    return op[OP_MULT] | op[OP_DIV];
  endfunction

endpackage

// File: rtl/muldiv_sched_hilo_regs.sv
// Architectural HI/LO registers. A result commit overrides MTHI/MTLO on the
// same edge; MT writes are suppressed while a flush is active.
module muldiv_hilo_regs
  import muldiv_sched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic [DATA_W-1:0] res_hi,
  input  logic [DATA_W-1:0] res_lo,
  input  logic              flush,
  input  logic              mt_hi_we,
  input  logic              mt_lo_we,
  input  logic [DATA_W-1:0] mt_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  logic [1:0][DATA_W-1:0] res_word;
  logic [1:0]             mt_we;

  assign res_word = {res_hi, res_lo};
  assign mt_we    = {mt_hi_we, mt_lo_we};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hilo
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          word_reg <= '0;
        end else if (commit) begin
          word_reg <= res_word[gi];
        end else if (mt_we[gi] && !flush) begin
          word_reg <= mt_data;
        end
      end
    end
  endgenerate

  assign lo = g_hilo[0].word_reg;
  assign hi = g_hilo[1].word_reg;

endmodule

// File: rtl/muldiv_sched.sv
// Multiply/divide sequencer: single-cycle multiplier, AXI-stream divider
// handshake with flush draining, and HI/LO commit on the EXE->MEM handshake.
module muldiv_sched
  import muldiv_sched_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter bit QUO_HIGH = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_op,
  input  logic [DATA_W-1:0]   req_src1,
  input  logic [DATA_W-1:0]   req_src2,
  input  logic                flush,
  output logic                div_signed,
  output logic                div_s_tvalid,
  input  logic                div_s_tready,
  output logic [DATA_W-1:0]   div_s_dividend,
  output logic [DATA_W-1:0]   div_s_divisor,
  input  logic                div_m_tvalid,
  input  logic [2*DATA_W-1:0] div_m_tdata,
  output logic                res_valid,
  input  logic                res_ready,
  output logic                busy,
  input  logic                mt_hi_we,
  input  logic                mt_lo_we,
  input  logic [DATA_W-1:0]   mt_data,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  md_state_e           state_reg;
  logic [DATA_W-1:0]   src1_reg;
  logic [DATA_W-1:0]   src2_reg;
  logic                signed_reg;
  logic [2*DATA_W-1:0] res_reg;
  logic                res_valid_reg;
  logic                tvalid_reg;

  logic                accept;
  logic                commit;
  logic [2*DATA_W-1:0] src1_ext;
  logic [2*DATA_W-1:0] src2_ext;
  logic [2*DATA_W-1:0] mul_prod;
  logic [2*DATA_W-1:0] div_res;

  assign accept = (state_reg == MD_IDLE) && req_valid && !flush && (req_op != '0);
  assign commit = (state_reg == MD_DONE) && res_ready && !flush;

  // Sign-extend only for signed ops; the low 2*DATA_W bits of the product are then right for both.
  assign src1_ext = {{DATA_W{signed_reg & src1_reg[DATA_W-1]}}, src1_reg};
  assign src2_ext = {{DATA_W{signed_reg & src2_reg[DATA_W-1]}}, src2_reg};
  assign mul_prod = src1_ext * src2_ext;

  // div_res is laid out as {hi = remainder, lo = quotient}.
  generate
    if (QUO_HIGH) begin : g_quo_high
      assign div_res = {div_m_tdata[DATA_W-1:0], div_m_tdata[2*DATA_W-1:DATA_W]};
    end else begin : g_quo_low
      assign div_res = div_m_tdata;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= MD_IDLE;
      src1_reg      <= '0;
      src2_reg      <= '0;
      signed_reg    <= 1'b0;
      res_reg       <= '0;
      res_valid_reg <= 1'b0;
      tvalid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        MD_IDLE: begin
          if (accept) begin
            src1_reg   <= req_src1;
            src2_reg   <= req_src2;
            signed_reg <= op_is_signed(req_op);
            if (op_is_div(req_op)) begin
              tvalid_reg <= 1'b1;
              state_reg  <= MD_DSEND;
            end else begin
              state_reg  <= MD_MUL;
            end
          end
        end
        MD_MUL: begin
          if (flush) begin
            state_reg <= MD_IDLE;
          end else begin
            res_reg       <= mul_prod;
            res_valid_reg <= 1'b1;
            state_reg     <= MD_DONE;
          end
        end
        MD_DSEND: begin
          if (div_s_tready) begin
            tvalid_reg <= 1'b0;
          end
          if (flush) begin
            state_reg <= MD_DRAIN;
          end else if (div_s_tready) begin
            state_reg <= MD_DWAIT;
          end
        end
        MD_DWAIT: begin
          if (div_m_tvalid) begin
            // A flush coinciding with dout already has its result in hand: drop it and go idle.
            if (flush) begin
              state_reg <= MD_IDLE;
            end else begin
              res_reg       <= div_res;
              res_valid_reg <= 1'b1;
              state_reg     <= MD_DONE;
            end
          end else if (flush) begin
            state_reg <= MD_DRAIN;
          end
        end
        MD_DRAIN: begin
          // Finish the pending send first, then swallow exactly one dout.
          if (tvalid_reg) begin
            if (div_s_tready) begin
              tvalid_reg <= 1'b0;
            end
          end else if (div_m_tvalid) begin
            state_reg <= MD_IDLE;
          end
        end
        MD_DONE: begin
          if (flush || res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= MD_IDLE;
          end
        end
        default: begin
          state_reg <= MD_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = (state_reg == MD_IDLE);
  assign busy           = (state_reg != MD_IDLE);
  assign div_signed     = signed_reg;
  assign div_s_tvalid   = tvalid_reg;
  assign div_s_dividend = src1_reg;
  assign div_s_divisor  = src2_reg;
  assign res_valid      = res_valid_reg;

  muldiv_hilo_regs #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk      (clk),
    .reset    (reset),
    .commit   (commit),
    .res_hi   (res_reg[2*DATA_W-1:DATA_W]),
    .res_lo   (res_reg[DATA_W-1:0]),
    .flush    (flush),
    .mt_hi_we (mt_hi_we),
    .mt_lo_we (mt_lo_we),
    .mt_data  (mt_data),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched with a behavioural divider IP model
// (programmable tready delay and dout latency).
module tb_muldiv_sched;

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_DIVU  = 4'b1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        div_signed;
  logic        div_s_tvalid;
  logic        div_s_tready;
  logic [31:0] div_s_dividend;
  logic [31:0] div_s_divisor;
  logic        div_m_tvalid;
  logic [63:0] div_m_tdata;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        mt_hi_we = 1'b0;
  logic        mt_lo_we = 1'b0;
  logic [31:0] mt_data = '0;
  logic [31:0] hi;
  logic [31:0] lo;

  always #5 clk = ~clk;

  muldiv_sched #(.DATA_W(32), .QUO_HIGH(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .div_signed(div_signed), .div_s_tvalid(div_s_tvalid), .div_s_tready(div_s_tready),
    .div_s_dividend(div_s_dividend), .div_s_divisor(div_s_divisor),
    .div_m_tvalid(div_m_tvalid), .div_m_tdata(div_m_tdata),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .mt_hi_we(mt_hi_we), .mt_lo_we(mt_lo_we), .mt_data(mt_data),
    .hi(hi), .lo(lo)
  );

  // ---------------- divider IP model ({quotient, remainder} layout) ----------------
  int          tready_delay = 0;
  int          latency = 3;
  int          tv_cnt, lat_cnt, tv_edges, hs_edges;
  logic        moved, hs_moved, ip_m_tvalid;
  logic        stale_m_tvalid = 1'b0;
  logic [31:0] first_a, first_b;
  logic [63:0] ip_dout;

  function automatic logic [63:0] ip_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  assign div_s_tready = div_s_tvalid && (tv_cnt >= tready_delay);
  assign div_m_tvalid = ip_m_tvalid | stale_m_tvalid;
  assign div_m_tdata  = ip_dout;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tv_cnt <= 0; lat_cnt <= 0; tv_edges <= 0; hs_edges <= 0;
      moved <= 1'b0; hs_moved <= 1'b0; ip_m_tvalid <= 1'b0;
      first_a <= '0; first_b <= '0; ip_dout <= '0;
    end else begin
      ip_m_tvalid <= 1'b0;
      if (lat_cnt == 1) ip_m_tvalid <= 1'b1;
      if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
      if (div_s_tvalid) begin
        if (tv_edges == 0) begin
          first_a <= div_s_dividend;
          first_b <= div_s_divisor;
        end
        if (div_s_tready) begin
          hs_edges <= tv_edges + 1;
          hs_moved <= moved | ((tv_edges != 0) &&
                      ((div_s_dividend != first_a) || (div_s_divisor != first_b)));
          tv_edges <= 0;
          moved    <= 1'b0;
          tv_cnt   <= 0;
          lat_cnt  <= latency;
          ip_dout  <= ip_div(div_signed, div_s_dividend, div_s_divisor);
        end else begin
          if ((tv_edges != 0) && ((div_s_dividend != first_a) || (div_s_divisor != first_b)))
            moved <= 1'b1;
          tv_edges <= tv_edges + 1;
          tv_cnt   <= tv_cnt + 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(negedge clk);
    req_valid = 1'b0; req_op = '0;
  endtask

  task automatic wait_res(input string name);
    int n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, " res_valid timeout"}, 64'(res_valid), 64'd1);
  endtask

  task automatic mt_write(input logic hw, input logic lw, input logic [31:0] d);
    @(negedge clk);
    mt_hi_we = hw; mt_lo_we = lw; mt_data = d;
    @(negedge clk);
    mt_hi_we = 1'b0; mt_lo_we = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[9];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3] = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[4] = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
    vecs[5] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[6] = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF};
    vecs[7] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8] = '{OP_DIV,   32'h80000000, 32'd1,        32'd0,        32'h80000000};

    // Reset state, observed while reset is still asserted.
    #1;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst res_valid", 64'(res_valid), 64'd0);
    chk("rst tvalid", 64'(div_s_tvalid), 64'd0);
    chk("rst div_signed", 64'(div_signed), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven operations.
    for (int i = 0; i < 9; i++) begin
      tready_delay = 1; latency = 3;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_res("vec");
      chk("vec busy", 64'(busy), 64'd1);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("vec res_valid drop", 64'(res_valid), 64'd0);
      chk("vec hi", 64'(hi), 64'(vecs[i].exp_hi));
      chk("vec lo", 64'(lo), 64'(vecs[i].exp_lo));
      $display("vec %0d op=%b a=%h b=%h -> hi=%h lo=%h", i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo);
    end

    // MULT -3 x 7 latency: res_valid exactly 2 edges after accept.
    res_ready = 1'b1;
    issue(OP_MULT, 32'hFFFFFFFD, 32'd7);
    chk("mul lat edge1 res_valid", 64'(res_valid), 64'd0);
    chk("mul lat edge1 busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("mul lat edge2 res_valid", 64'(res_valid), 64'd1);
    @(negedge clk);
    res_ready = 1'b0;
    chk("mul lat hi", 64'(hi), 64'hFFFFFFFF);
    chk("mul lat lo", 64'(lo), 64'hFFFFFFEB);
    $display("seq mult latency hi=%h lo=%h", hi, lo);

    // DIVU 100/7 with tready 3 cycles late and dout latency 20.
    begin
      int n = 0;
      logic busy_drop = 1'b0;
      tready_delay = 3; latency = 20;
      issue(OP_DIVU, 32'd100, 32'd7);
      while (!res_valid && n < 100) begin
        if (!busy) busy_drop = 1'b1;
        @(negedge clk);
        n++;
      end
      chk("divu slow res_valid", 64'(res_valid), 64'd1);
      chk("divu slow busy held", 64'(busy_drop), 64'd0);
      chk("divu slow tvalid edges", 64'(hs_edges), 64'd4);
      chk("divu slow data stable", 64'(hs_moved), 64'd0);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("divu slow lo", 64'(lo), 64'd14);
      chk("divu slow hi", 64'(hi), 64'd2);
      $display("seq divu slow hi=%h lo=%h", hi, lo);
    end

    // DIV -7/2 with res_ready held low for 5 cycles.
    mt_write(1'b1, 1'b0, 32'hAAAA0000);
    mt_write(1'b0, 1'b1, 32'h00005555);
    tready_delay = 0; latency = 2;
    issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
    wait_res("div hold");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("div hold res_valid", 64'(res_valid), 64'd1);
      chk("div hold hi", 64'(hi), 64'hAAAA0000);
      chk("div hold lo", 64'(lo), 64'h00005555);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("div hold lo commit", 64'(lo), 64'hFFFFFFFD);
    chk("div hold hi commit", 64'(hi), 64'hFFFFFFFF);
    $display("seq div hold hi=%h lo=%h", hi, lo);

    // Flush in DWAIT of DIVU 9/3: drain, block requests, discard dout.
    begin
      int n = 0;
      logic ready_seen = 1'b0;
      mt_write(1'b1, 1'b0, 32'h11);
      mt_write(1'b0, 1'b1, 32'h22);
      tready_delay = 0; latency = 10;
      issue(OP_DIVU, 32'd9, 32'd3);
      @(negedge clk);
      chk("drain dwait tvalid", 64'(div_s_tvalid), 64'd0);
      chk("drain dwait busy", 64'(busy), 64'd1);
      flush = 1'b1; req_valid = 1'b1; req_op = OP_MULT; req_src1 = 32'd5; req_src2 = 32'd5;
      @(negedge clk);
      flush = 1'b0;
      while (!ip_m_tvalid && n < 50) begin
        if (req_ready) ready_seen = 1'b1;
        @(negedge clk);
        n++;
      end
      chk("drain dout seen", 64'(ip_m_tvalid), 64'd1);
      chk("drain req_ready low", 64'(ready_seen | req_ready), 64'd0);
      req_valid = 1'b0; req_op = '0;
      @(negedge clk);
      chk("drain idle after dout", 64'(req_ready), 64'd1);
      chk("drain res_valid", 64'(res_valid), 64'd0);
      chk("drain hi kept", 64'(hi), 64'h11);
      chk("drain lo kept", 64'(lo), 64'h22);
      $display("seq flush dwait hi=%h lo=%h", hi, lo);
    end

    // MTHI in IDLE, then MTHI blocked by flush.
    mt_write(1'b1, 1'b0, 32'h1234);
    chk("mthi idle", 64'(hi), 64'h1234);
    @(negedge clk);
    mt_hi_we = 1'b1; mt_data = 32'h9999; flush = 1'b1;
    @(negedge clk);
    mt_hi_we = 1'b0; flush = 1'b0;
    chk("mthi flushed", 64'(hi), 64'h1234);
    $display("seq mthi hi=%h", hi);

    // MTLO coinciding with DIVU 100/7 commit: the result wins.
    tready_delay = 0; latency = 2;
    issue(OP_DIVU, 32'd100, 32'd7);
    wait_res("mt vs commit");
    res_ready = 1'b1; mt_lo_we = 1'b1; mt_data = 32'hDEAD;
    @(negedge clk);
    res_ready = 1'b0; mt_lo_we = 1'b0;
    chk("mt vs commit lo", 64'(lo), 64'd14);
    chk("mt vs commit hi", 64'(hi), 64'd2);
    $display("seq mtlo vs commit hi=%h lo=%h", hi, lo);

    // Flush and res_ready together in DONE: no commit.
    issue(OP_MULTU, 32'd5, 32'd6);
    wait_res("flush done");
    res_ready = 1'b1; flush = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; flush = 1'b0;
    chk("flush done res_valid", 64'(res_valid), 64'd0);
    chk("flush done idle", 64'(req_ready), 64'd1);
    chk("flush done lo", 64'(lo), 64'd14);
    $display("seq flush in done hi=%h lo=%h", hi, lo);

    // Flush in MUL: no result.
    issue(OP_MULT, 32'd3, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush mul idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    chk("flush mul res_valid", 64'(res_valid), 64'd0);
    chk("flush mul lo", 64'(lo), 64'd14);
    $display("seq flush in mul lo=%h", lo);

    // Stale dout in IDLE is ignored.
    @(negedge clk);
    stale_m_tvalid = 1'b1;
    @(negedge clk);
    stale_m_tvalid = 1'b0;
    chk("stale busy", 64'(busy), 64'd0);
    chk("stale res_valid", 64'(res_valid), 64'd0);
    $display("seq stale dout busy=%b", busy);

    // Asynchronous reset mid-DSEND.
    tready_delay = 1000;
    issue(OP_DIV, 32'd50, 32'd5);
    chk("arst pre tvalid", 64'(div_s_tvalid), 64'd1);
    chk("arst pre div_signed", 64'(div_signed), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst tvalid", 64'(div_s_tvalid), 64'd0);
    chk("arst div_signed", 64'(div_signed), 64'd0);
    chk("arst hi", 64'(hi), 64'd0);
    chk("arst lo", 64'(lo), 64'd0);
    chk("arst idle", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    $display("seq async reset tvalid=%b hi=%h lo=%h", div_s_tvalid, hi, lo);

    // Operation after reset.
    tready_delay = 0; latency = 3;
    issue(OP_MULTU, 32'd6, 32'd7);
    wait_res("post rst");
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("post rst lo", 64'(lo), 64'd42);
    chk("post rst hi", 64'(hi), 64'd0);
    $display("seq post reset hi=%h lo=%h", hi, lo);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencer for the EXE-stage multiply/divide resource.
- Accepts one MULT/MULTU/DIV/DIVU op at a time from EXE and drives the signed/unsigned divider IP AXI-stream handshake.
- Handles flush-while-busy by draining the in-flight divide, then commits the result to architectural HI/LO.
- Also services MTHI/MTLO writes. EXE uses `busy`/`res_valid` as its ready_go term.

Parameters:
- DATA_W, 32, operand/HI/LO width
- QUO_HIGH, 1, 1: divider dout = {quotient, remainder}; 0: {remainder, quotient}

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  op request from EXE
- req_ready  out  1  request accepted this cycle (= state IDLE)
- req_op  in  4  one-hot {divu, div, multu, mult}
- req_src1  in  DATA_W  dividend / multiplicand (rs)
- req_src2  in  DATA_W  divisor / multiplier (rt)
- flush  in  1  exception/eret flush from WB; cancels current op
- div_signed  out  1  selects signed IP (1) or unsigned IP (0)
- div_s_tvalid  out  1  divisor+dividend tvalid (shared)
- div_s_tready  in  1  AND of the selected IP's divisor/dividend tready
- div_s_dividend  out  DATA_W  registered dividend
- div_s_divisor  out  DATA_W  registered divisor
- div_m_tvalid  in  1  selected IP's dout tvalid
- div_m_tdata  in  2*DATA_W  selected IP's dout
- res_valid  out  1  result ready; HI/LO commit on handshake
- res_ready  in  1  EXE→MEM advance (ms_allowin and no downstream exception)
- busy  out  1  state != IDLE
- mt_hi_we, mt_lo_we  in  1  MTHI/MTLO write strobes
- mt_data  in  DATA_W  MTHI/MTLO data
- hi, lo  out  DATA_W  architectural HI/LO

Behaviour:
- Async reset: state=IDLE; hi=lo=0; res_valid, div_s_tvalid, div_signed=0; operand registers=0.
- States: IDLE, MUL, DSEND, DWAIT, DONE, DRAIN.
- IDLE:
  - req_valid & ~flush & req_op!=0 → latch src1/src2/op.
  - mult/multu → MUL.
  - div/divu → DSEND with div_s_tvalid=1 from the next cycle.
  - req_op with more than one bit set: behaviour undefined; the bench does not drive it.
- MUL:
  - One cycle; product is signed or unsigned per op.
  - Result register = {hi, lo} of the 2*DATA_W product.
  - → DONE. Latency from req accept to res_valid is 2 edges.
- DSEND:
  - div_s_tvalid held at 1 with stable data until div_s_tready=1 at an edge.
  - Then tvalid drops → DWAIT.
- DWAIT:
  - On div_m_tvalid, capture HI=remainder, LO=quotient, mapped per QUO_HIGH.
  - → DONE.
- DONE:
  - res_valid=1.
  - On res_ready: hi/lo updated at that edge, res_valid drops → IDLE.
- Flush:
  - In MUL or DONE → IDLE; no HI/LO write.
  - In DSEND → DRAIN. The sender keeps tvalid until accepted, because AXI-stream must not retract. In DRAIN, tvalid stays high until tready; after acceptance, wait for div_m_tvalid.
  - In DWAIT → DRAIN.
  - DRAIN discards the result → IDLE. No new request is accepted while draining.
  - Flush in IDLE has no effect on HI/LO.
- Flush and res_ready in the same cycle: flush wins; no commit.
- MTHI/MTLO:
  - Write hi/lo at the edge when ~flush.
  - Accepted in any state.
  - Same-edge conflict with a result commit: the result commit wins for both registers.
- Divide by zero: no trap; HI/LO take whatever the IP returns.
- div_signed is latched from the op at accept and held until return to IDLE, including through DRAIN.
- Stale result protection: div_m_tvalid seen in IDLE/MUL/DONE is ignored.

Decomposition:
- Shared header mycpu.h holds:
  - state encodings `MD_IDLE…`MD_DRAIN
  - req_op bit indices aligned with the existing alu_op mult/div bits (12..15)
- Sub-module `muldiv_hilo_regs`: HI/LO registers with the commit/MT priority mux.
- FSM, operand latch and multiplier stay in muldiv_sched.

Test Plan:
- MULT -3 × 7: req_valid 1 cycle, res_ready=1 → res_valid 2 edges after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 with IP model tready delayed 3 cycles, latency 20:
  - tvalid held 4 cycles with stable data;
  - DONE after dout; on commit lo=14, hi=2; busy high throughout.
- DIV -7/2 signed, res_ready held low 5 cycles:
  - res_valid stays high, hi/lo unchanged until ready;
  - then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Flush in DWAIT of DIVU 9/3:
  - state DRAIN, req_ready=0 despite req_valid;
  - dout discarded; hi/lo retain prior values; IDLE the cycle after dout.
- MTHI 0x1234 in IDLE → hi=0x1234 next edge. MTLO coinciding with DONE commit → lo equals the div result, not mt_data.
- Async reset asserted mid-DSEND:
  - div_s_tvalid drops immediately (no clock edge needed);
  - hi=lo=0, state IDLE.
